// File: rtl/muldiv_pkg.sv
// Shared types for the HI/LO multiply/divide unit: operation codes, FSM states
// and small operation-class helpers.
package muldiv_pkg;

  typedef enum logic [2:0] {
    MULT  = 3'd0,
    MULTU = 3'd1,
    DIV   = 3'd2,
    DIVU  = 3'd3,
    MTHI  = 3'd4,
    MTLO  = 3'd5
  } muldiv_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } muldiv_state_t;

  function automatic logic op_is_arith(input muldiv_op_t op);
    return (op == MULT) || (op == MULTU) || (op == DIV) || (op == DIVU);
  endfunction

  function automatic logic op_is_div(input muldiv_op_t op);
    return (op == DIV) || (op == DIVU);
  endfunction

  function automatic logic op_is_signed(input muldiv_op_t op);
    return (op == MULT) || (op == DIV);
  endfunction

endpackage

// File: rtl/muldiv_sign_adj.sv
// Combinational two's-complement conditional negate; with i_neg tied to the
// sign bit it yields the magnitude of a signed value.
module muldiv_sign_adj #(
  parameter int W = 32
) (
  input  logic [W-1:0] i_val,
  input  logic         i_neg,
  output logic [W-1:0] o_val
);

  assign o_val = i_neg ? (~i_val + W'(1)) : i_val;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit owning HI/LO. Define MULDIV_FAST_MUL_EN to
// replace the shift-add multiply with a single-cycle combinational multiplier.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  muldiv_op_t       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  localparam int CW = $clog2(WIDTH + 1);

  muldiv_state_t    r_state;
  muldiv_state_t    w_state_nxt;
  logic [CW-1:0]    r_cnt;
  logic             r_is_div;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_div_zero;
  logic [WIDTH-1:0] r_dvsr;
  logic [WIDTH-1:0] r_work_hi;
  logic [WIDTH-1:0] r_work_lo;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_done;

  logic             w_idle;
  logic             w_accept;
  logic             w_accept_arith;
  logic             w_fast_accept;
  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;

  logic [WIDTH:0]     w_mul_sum;
  logic [WIDTH:0]     w_div_shift;
  logic               w_div_ge;
  logic [WIDTH-1:0]   w_div_sub;
  logic [2*WIDTH-1:0] w_prod_raw;
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0]   w_quo_fix;
  logic [WIDTH-1:0]   w_rem_fix;

  assign w_idle         = (r_state == ST_IDLE);
  assign w_accept       = w_idle & i_start;
  assign w_accept_arith = w_accept & op_is_arith(i_op);
  assign w_a_neg        = op_is_signed(i_op) & i_a[WIDTH-1];
  assign w_b_neg        = op_is_signed(i_op) & i_b[WIDTH-1];

`ifdef MULDIV_FAST_MUL_EN
  assign w_fast_accept = ~op_is_div(i_op);
  assign w_prod_raw    = {{WIDTH{1'b0}}, r_dvsr} * {{WIDTH{1'b0}}, r_work_lo};
`else
  assign w_fast_accept = 1'b0;
  assign w_prod_raw    = {r_work_hi, r_work_lo};
`endif

  muldiv_sign_adj #(.W(WIDTH)) u_abs_a (
    .i_val (i_a),
    .i_neg (w_a_neg),
    .o_val (w_abs_a)
  );

  muldiv_sign_adj #(.W(WIDTH)) u_abs_b (
    .i_val (i_b),
    .i_neg (w_b_neg),
    .o_val (w_abs_b)
  );

  muldiv_sign_adj #(.W(2*WIDTH)) u_fix_prod (
    .i_val (w_prod_raw),
    .i_neg (r_neg_q),
    .o_val (w_prod_fix)
  );

  muldiv_sign_adj #(.W(WIDTH)) u_fix_quo (
    .i_val (r_work_lo),
    .i_neg (r_neg_q),
    .o_val (w_quo_fix)
  );

  // Remainder follows the dividend sign; for a zero divisor it rebuilds a itself.
  muldiv_sign_adj #(.W(WIDTH)) u_fix_rem (
    .i_val (r_work_hi),
    .i_neg (r_neg_r),
    .o_val (w_rem_fix)
  );

  assign w_mul_sum   = {1'b0, r_work_hi} + (r_work_lo[0] ? {1'b0, r_dvsr} : '0);
  assign w_div_shift = {r_work_hi, r_work_lo[WIDTH-1]};
  assign w_div_ge    = (w_div_shift >= {1'b0, r_dvsr});
  assign w_div_sub   = w_div_shift[WIDTH-1:0] - r_dvsr;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept_arith) begin
          w_state_nxt = w_fast_accept ? ST_FIX : ST_CALC;
        end
      end
      ST_CALC: begin
        if (r_cnt == CW'(1)) begin
          w_state_nxt = ST_FIX;
        end
      end
      ST_FIX:  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt      <= '0;
      r_is_div   <= 1'b0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_div_zero <= 1'b0;
      r_dvsr     <= '0;
      r_work_hi  <= '0;
      r_work_lo  <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_done     <= 1'b0;
    end else begin
      r_done <= (r_state == ST_FIX);
      case (r_state)
        ST_IDLE: begin
          if (w_accept_arith) begin
            r_cnt      <= CW'(WIDTH);
            r_is_div   <= op_is_div(i_op);
            r_neg_q    <= w_a_neg ^ w_b_neg;
            r_neg_r    <= w_a_neg;
            r_div_zero <= op_is_div(i_op) && (i_b == '0);
            r_work_hi  <= '0;
            if (op_is_div(i_op)) begin
              r_work_lo <= w_abs_a;
              r_dvsr    <= w_abs_b;
            end else begin
              r_work_lo <= w_abs_b;
              r_dvsr    <= w_abs_a;
            end
          end else if (w_accept && (i_op == MTHI)) begin
            r_hi <= i_a;
          end else if (w_accept && (i_op == MTLO)) begin
            r_lo <= i_a;
          end
        end
        ST_CALC: begin
          r_cnt <= r_cnt - CW'(1);
          if (r_is_div) begin
            r_work_hi <= w_div_ge ? w_div_sub : w_div_shift[WIDTH-1:0];
            r_work_lo <= {r_work_lo[WIDTH-2:0], w_div_ge};
          end else begin
            {r_work_hi, r_work_lo} <= {w_mul_sum, r_work_lo[WIDTH-1:1]};
          end
        end
        ST_FIX: begin
          if (r_is_div) begin
            r_hi <= w_rem_fix;
            r_lo <= r_div_zero ? '1 : w_quo_fix;
          end else begin
            {r_hi, r_lo} <= w_prod_fix;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_busy = ~w_idle;
  assign o_done = r_done;
  assign o_hi   = r_hi;
  assign o_lo   = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed corner cases, random ops,
// MTHI/MTLO, busy-time start rejection and reset abort.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int WIDTH = 32;
`ifdef MULDIV_FAST_MUL_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  muldiv_op_t       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(WIDTH)) dut (
    .i_clk   (clk),
    .i_reset (reset),
    .i_start (start),
    .i_op    (op),
    .i_a     (a),
    .i_b     (b),
    .o_busy  (busy),
    .o_done  (done),
    .o_hi    (hi),
    .o_lo    (lo)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model(input muldiv_op_t o, input logic [31:0] x, input logic [31:0] y);
    longint      sp;
    int          sx;
    int          sy;
    logic [31:0] q;
    logic [31:0] r;
    sx = $signed(x);
    sy = $signed(y);
    case (o)
      MULT: begin
        sp = longint'(sx) * longint'(sy);
        return sp;
      end
      MULTU: return {32'h0, x} * {32'h0, y};
      DIV: begin
        if (y == 32'h0) return {x, 32'hFFFF_FFFF};
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        q = sx / sy;
        r = sx % sy;
        return {r, q};
      end
      default: begin
        if (y == 32'h0) return {x, 32'hFFFF_FFFF};
        return {x % y, x / y};
      end
    endcase
  endfunction

  // Entered and left on a falling edge, so consecutive calls issue back-to-back.
  task automatic run_arith(input string tag, input muldiv_op_t o, input logic [31:0] x,
                           input logic [31:0] y, input logic [31:0] e_hi, input logic [31:0] e_lo);
    exp_t e;
    int   nb;
    int   exp_busy;
    e.hi = e_hi;
    e.lo = e_lo;
    sb_q.push_back(e);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = $urandom;
    b     = $urandom;
    nb    = 0;
    do begin
      @(negedge clk);
      if (busy) nb++;
    end while (busy && nb < 200);
    exp_busy = (FAST && (o == MULT || o == MULTU)) ? 1 : WIDTH + 1;
    check({tag, "_busy_cycles"}, 64'(nb), 64'(exp_busy));
    check({tag, "_done"}, {63'h0, done}, 64'h1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check({tag, "_hi"}, {32'h0, hi}, {32'h0, e.hi});
      check({tag, "_lo"}, {32'h0, lo}, {32'h0, e.lo});
    end
  endtask

  task automatic run_mt(input string tag, input muldiv_op_t o, input logic [31:0] x);
    logic [63:0] prev;
    logic [63:0] exp;
    prev  = {hi, lo};
    exp   = (o == MTHI) ? {x, prev[31:0]} : {prev[63:32], x};
    start = 1'b1;
    op    = o;
    a     = x;
    @(posedge clk);
    #1;
    start = 1'b0;
    check({tag, "_busy"}, {63'h0, busy}, 64'h0);
    check({tag, "_done"}, {63'h0, done}, 64'h0);
    check({tag, "_hilo"}, {hi, lo}, exp);
    @(negedge clk);
  endtask

  initial begin
    logic [63:0] m;
    logic [63:0] prev;
    muldiv_op_t  ro;
    logic [31:0] ra;
    logic [31:0] rb;
    int          nd;

    reset = 1'b1;
    start = 1'b0;
    op    = MULT;
    a     = '0;
    b     = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy", {63'h0, busy}, 64'h0);
    check("reset_done", {63'h0, done}, 64'h0);
    check("reset_hilo", {hi, lo}, 64'h0);
    reset = 1'b0;
    @(negedge clk);

    run_arith("multu_max", MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    @(negedge clk);
    check("done_one_cycle", {63'h0, done}, 64'h0);

    run_arith("mult_m3x5", MULT, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    run_arith("mult_m4xm6", MULT, 32'hFFFF_FFFC, 32'hFFFF_FFFA, 32'h0, 32'd24);
    run_arith("div_m7d2", DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_arith("divu_7d2", DIVU, 32'd7, 32'd2, 32'd1, 32'd3);
    run_arith("div_7dm2", DIV, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD);
    run_arith("div_by0", DIV, 32'h0000_1234, 32'h0, 32'h0000_1234, 32'hFFFF_FFFF);
    run_arith("div_neg_by0", DIV, 32'hFFFF_FFFB, 32'h0, 32'hFFFF_FFFB, 32'hFFFF_FFFF);
    run_arith("divu_by0", DIVU, 32'hCAFE_F00D, 32'h0, 32'hCAFE_F00D, 32'hFFFF_FFFF);
    run_arith("div_minneg", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);
    run_arith("mult_minneg", MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0);

    run_mt("mthi", MTHI, 32'hDEAD_BEEF);
    run_mt("mtlo", MTLO, 32'h1234_5678);

    for (int i = 0; i < 8; i++) begin
      ro = muldiv_op_t'($urandom_range(0, 3));
      ra = $urandom;
      rb = (i == 5) ? 32'h0 : $urandom;
      if (i == 2) rb = rb >> 20;
      m = model(ro, ra, rb);
      run_arith($sformatf("rand%0d", i), ro, ra, rb, m[63:32], m[31:0]);
    end

    start = 1'b1;
    op    = DIVU;
    a     = 32'd1000;
    b     = 32'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    prev  = {hi, lo};
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (i == 3) begin
        start = 1'b1;
        op    = MTLO;
        a     = 32'h5555_5555;
      end
      if (i == 5) begin
        start = 1'b0;
        check("busy_start_ignored_hilo", {hi, lo}, prev);
        check("busy_start_ignored_busy", {63'h0, busy}, 64'h1);
      end
      if (i == 10) reset = 1'b1;
    end
    @(negedge clk);
    check("abort_busy", {63'h0, busy}, 64'h0);
    check("abort_done", {63'h0, done}, 64'h0);
    check("abort_hilo", {hi, lo}, 64'h0);
    reset = 1'b0;
    nd = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) nd++;
    end
    check("abort_no_done", 64'(nd), 64'h0);
    check("abort_hilo_held", {hi, lo}, 64'h0);

    run_arith("divu_after_abort", DIVU, 32'd100, 32'd7, 32'd2, 32'd14);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
